// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: issues sequential word fetches, buffers {pc, insn}
// in a small queue for decode, and handles redirects by flushing and dropping stale responses.
module fetch_queue #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              rsp_valid_i,
    input  logic [DWIDTH-1:0] rsp_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] rsp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [AWIDTH-1:0] pc_mem   [QDEPTH];
    logic [DWIDTH-1:0] insn_mem [QDEPTH];

    logic [CW:0]       in_use;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [AWIDTH-1:0] redirect_target;

    // A fetch may only be issued if the queue has room for its response,
    // counting every response still in flight.
    assign in_use          = {1'b0, count} + {1'b0, outstanding};
    assign req_valid_o     = !rst && !redirect_i && (in_use < (CW+1)'(QDEPTH));
    assign req_addr_o      = fetch_pc;
    assign req_fire        = req_valid_o && req_ready_i;
    assign push            = rsp_valid_i && (drop == '0);
    assign pop             = valid_o && ready_i;
    assign redirect_target = redirect_pc_i & ~AWIDTH'(3);

    assign valid_o = (count != '0);
    assign pc_o    = valid_o ? pc_mem[rd_ptr]   : '0;
    assign insn_o  = valid_o ? insn_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && !redirect_i && push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            insn_mem[wr_ptr] <= rsp_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= BASEADDR;
            rsp_pc      <= BASEADDR;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_valid_i);
            if (redirect_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop     <= outstanding - CW'(rsp_valid_i);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + AWIDTH'(4);
                if (rsp_valid_i) begin
                    if (drop != '0)
                        drop <= drop - CW'(1);
                    else
                        rsp_pc <= rsp_pc + AWIDTH'(4);
                end
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-configurable in-order memory model
// and hand-computed PC sequences.
module tb_fetch_queue;
    localparam logic [31:0] BASE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;

    int checks = 0;
    int passes = 0;
    int mem_lat = 1;
    logic        pipe_v [1:4];
    logic [31:0] pipe_a [1:4];

    fetch_queue dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    // One clock: sample the request handshake, advance the memory pipeline, drive the response.
    task automatic tick();
        logic        fire;
        logic        rst_q;
        logic [31:0] fa;
        #1;
        fire  = req_valid_o && req_ready_i;
        fa    = req_addr_o;
        rst_q = rst;
        @(posedge clk);
        #1;
        if (rst_q) begin
            for (int i = 1; i <= 4; i++) begin
                pipe_v[i] = 1'b0;
                pipe_a[i] = '0;
            end
        end else begin
            for (int i = 4; i >= 2; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_a[i] = pipe_a[i-1];
            end
            pipe_v[1] = fire;
            pipe_a[1] = fa;
        end
        rsp_valid_i = pipe_v[mem_lat];
        rsp_data_i  = pipe_v[mem_lat] ? mem_word(pipe_a[mem_lat]) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        req_ready_i = 1'b1; ready_i = 1'b0; mem_lat = 1;
        rsp_valid_i = 1'b0; rsp_data_i = '0;
        tick();
        tick();
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid_o); else passes++;
        checks++; if (pc_o !== 32'h0) $display("[TB] FAIL reset_pc: got %h want 0", pc_o); else passes++;
        checks++; if (insn_o !== 32'h0) $display("[TB] FAIL reset_insn: got %h want 0", insn_o); else passes++;
        checks++; if (req_valid_o !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b want 0", req_valid_o); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (req_valid_o !== 1'b1) $display("[TB] FAIL first_req_valid: got %b want 1", req_valid_o); else passes++;
        checks++; if (req_addr_o !== BASE) $display("[TB] FAIL first_req_addr: got %h want %h", req_addr_o, BASE); else passes++;
    endtask

    task automatic test_stream(inout logic [31:0] exp);
        ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL stream_valid_c1: got %b want 0", valid_o); else passes++;
        tick();
        checks++; if (valid_o !== 1'b1) $display("[TB] FAIL stream_valid_c2: got %b want 1", valid_o); else passes++;
        exp = BASE;
        for (int i = 0; i < 6; i++) begin
            checks++; if (valid_o !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b want 1", i, valid_o); else passes++;
            checks++; if (pc_o !== exp) $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, pc_o, exp); else passes++;
            checks++; if (insn_o !== mem_word(exp)) $display("[TB] FAIL stream_insn[%0d]: got %h want %h", i, insn_o, mem_word(exp)); else passes++;
            exp += 4;
            tick();
        end
    endtask

    task automatic test_backpressure(inout logic [31:0] exp);
        int n;
        ready_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (valid_o !== 1'b1) $display("[TB] FAIL full_valid: got %b want 1", valid_o); else passes++;
        checks++; if (req_valid_o !== 1'b0) $display("[TB] FAIL full_req_valid: got %b want 0", req_valid_o); else passes++;
        checks++; if (pc_o !== exp) $display("[TB] FAIL full_head_pc: got %h want %h", pc_o, exp); else passes++;
        ready_i = 1'b1;
        #1;
        checks++; if (req_valid_o !== 1'b0) $display("[TB] FAIL credit_same_cycle: got %b want 0", req_valid_o); else passes++;
        tick();
        exp += 4;
        checks++; if (req_valid_o !== 1'b1) $display("[TB] FAIL credit_next_cycle: got %b want 1", req_valid_o); else passes++;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (valid_o) begin
                checks++; if (pc_o !== exp) $display("[TB] FAIL drain_pc[%0d]: got %h want %h", i, pc_o, exp); else passes++;
                checks++; if (insn_o !== mem_word(exp)) $display("[TB] FAIL drain_insn[%0d]: got %h want %h", i, insn_o, mem_word(exp)); else passes++;
                exp += 4;
                n++;
            end
            tick();
        end
        checks++; if (n !== 16) $display("[TB] FAIL drain_count: got %0d want 16", n); else passes++;
    endtask

    task automatic test_redirect_stale();
        logic [31:0] exp;
        int n;
        int first;
        mem_lat = 3; ready_i = 1'b1; req_ready_i = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL stale_pre_valid: got %b want 0", valid_o); else passes++;
        redirect_i = 1'b1; redirect_pc_i = 32'h01000103;
        #1;
        checks++; if (req_valid_o !== 1'b0) $display("[TB] FAIL stale_redirect_req: got %b want 0", req_valid_o); else passes++;
        tick();
        redirect_i = 1'b0;
        #1;
        checks++; if (req_valid_o !== 1'b1) $display("[TB] FAIL stale_req_valid: got %b want 1", req_valid_o); else passes++;
        checks++; if (req_addr_o !== 32'h01000100) $display("[TB] FAIL stale_req_addr: got %h want 01000100", req_addr_o); else passes++;
        exp = 32'h01000100; n = 0; first = -1;
        for (int i = 0; i < 12; i++) begin
            if (valid_o) begin
                if (first < 0) first = i;
                checks++; if (pc_o !== exp) $display("[TB] FAIL stale_pc[%0d]: got %h want %h", i, pc_o, exp); else passes++;
                checks++; if (insn_o !== mem_word(exp)) $display("[TB] FAIL stale_insn[%0d]: got %h want %h", i, insn_o, mem_word(exp)); else passes++;
                exp += 4;
                n++;
            end
            tick();
        end
        checks++; if (first !== 4) $display("[TB] FAIL stale_first_valid: got %0d want 4", first); else passes++;
        checks++; if (n < 2) $display("[TB] FAIL stale_count: got %0d want >=2", n); else passes++;
    endtask

    task automatic test_redirect_same_cycle();
        mem_lat = 1; ready_i = 1'b1; req_ready_i = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        checks++; if (valid_o !== 1'b1) $display("[TB] FAIL same_pre_valid: got %b want 1", valid_o); else passes++;
        checks++; if (pc_o !== BASE + 32'd4) $display("[TB] FAIL same_pre_pc: got %h want %h", pc_o, BASE + 32'd4); else passes++;
        redirect_i = 1'b1; redirect_pc_i = 32'h00002002;
        tick();
        redirect_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL same_flush_valid: got %b want 0", valid_o); else passes++;
        checks++; if (req_valid_o !== 1'b1) $display("[TB] FAIL same_req_valid: got %b want 1", req_valid_o); else passes++;
        checks++; if (req_addr_o !== 32'h00002000) $display("[TB] FAIL same_req_addr: got %h want 00002000", req_addr_o); else passes++;
        tick();
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL same_valid_n2: got %b want 0", valid_o); else passes++;
        tick();
        checks++; if (valid_o !== 1'b1) $display("[TB] FAIL same_valid_n3: got %b want 1", valid_o); else passes++;
        checks++; if (pc_o !== 32'h00002000) $display("[TB] FAIL same_target_pc: got %h want 00002000", pc_o); else passes++;
        checks++; if (insn_o !== mem_word(32'h00002000)) $display("[TB] FAIL same_target_insn: got %h want %h", insn_o, mem_word(32'h00002000)); else passes++;
    endtask

    task automatic test_random_stall();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        logic        stalled;
        int n;
        mem_lat = 2; ready_i = 1'b1; req_ready_i = 1'b1;
        do_reset();
        exp_pc = BASE; exp_req = BASE; stalled = 1'b0; n = 0;
        for (int i = 0; i < 60; i++) begin
            req_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                checks++; if (req_valid_o !== 1'b1) $display("[TB] FAIL stall_hold_valid[%0d]: got %b want 1", i, req_valid_o); else passes++;
            end
            stalled = 1'b0;
            if (req_valid_o) begin
                checks++; if (req_addr_o !== exp_req) $display("[TB] FAIL stall_req_addr[%0d]: got %h want %h", i, req_addr_o, exp_req); else passes++;
                if (req_ready_i) exp_req += 4;
                else stalled = 1'b1;
            end
            if (valid_o) begin
                checks++; if (pc_o !== exp_pc) $display("[TB] FAIL stall_pc[%0d]: got %h want %h", i, pc_o, exp_pc); else passes++;
                checks++; if (insn_o !== mem_word(exp_pc)) $display("[TB] FAIL stall_insn[%0d]: got %h want %h", i, insn_o, mem_word(exp_pc)); else passes++;
                exp_pc += 4;
                n++;
            end
            tick();
        end
        checks++; if (n < 10) $display("[TB] FAIL stall_pop_count: got %0d want >=10", n); else passes++;
    endtask

    task automatic test_reset_midstream();
        req_ready_i = 1'b1; ready_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (valid_o !== 1'b1) $display("[TB] FAIL mid_pre_valid: got %b want 1", valid_o); else passes++;
        rst = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL mid_valid: got %b want 0", valid_o); else passes++;
        checks++; if (pc_o !== 32'h0) $display("[TB] FAIL mid_pc: got %h want 0", pc_o); else passes++;
        checks++; if (insn_o !== 32'h0) $display("[TB] FAIL mid_insn: got %h want 0", insn_o); else passes++;
        checks++; if (req_valid_o !== 1'b0) $display("[TB] FAIL mid_req_valid: got %b want 0", req_valid_o); else passes++;
        tick();
        mem_lat = 1;
        rst = 1'b0;
        #1;
        checks++; if (req_addr_o !== BASE) $display("[TB] FAIL mid_restart_addr: got %h want %h", req_addr_o, BASE); else passes++;
        ready_i = 1'b1;
        tick();
        tick();
        checks++; if (pc_o !== BASE) $display("[TB] FAIL mid_restart_pc0: got %h want %h", pc_o, BASE); else passes++;
        tick();
        checks++; if (pc_o !== BASE + 32'd4) $display("[TB] FAIL mid_restart_pc1: got %h want %h", pc_o, BASE + 32'd4); else passes++;
    endtask

    initial begin
        logic [31:0] exp;
        for (int i = 1; i <= 4; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
        exp = BASE;
        test_reset();
        test_stream(exp);
        test_backpressure(exp);
        test_redirect_stale();
        test_redirect_same_cycle();
        test_random_stall();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised, decoupled instruction fetch stage for the RISC-V core.
- Issues sequential word fetches to instruction memory over a request/response interface that tolerates multi-cycle latency.
- Buffers returned instructions with their PCs in a QDEPTH-entry queue.
- Presents them to decode through a valid/ready handshake.
- Supports PC redirect (branch/jump) with queue flush and discard of stale in-flight responses.

## Interface
Parameters:
- DWIDTH, 32, instruction width
- AWIDTH, 32, address/PC width
- BASEADDR, 32'h01000000, PC after reset
- QDEPTH, 4, instruction queue depth and maximum fetches in flight; power of two, >= 2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- redirect_i  in  1  load new fetch PC this cycle
- redirect_pc_i  in  AWIDTH  redirect target; bits [1:0] forced to 0
- req_valid_o  out  1  fetch request valid
- req_ready_i  in  1  memory accepts request
- req_addr_o  out  AWIDTH  fetch address
- rsp_valid_i  in  1  response valid; responses return in request order
- rsp_data_i  in  DWIDTH  fetched instruction
- valid_o  out  1  queue head valid
- ready_i  in  1  decode accepts head
- pc_o  out  AWIDTH  PC of head entry
- insn_o  out  DWIDTH  instruction of head entry

## Operation
State:
- fetch_pc: next request address.
- rsp_pc: PC of the next non-dropped response.
- outstanding: accepted requests not yet responded; width clog2(QDEPTH+1).
- drop: oldest in-flight responses still to discard.
- Queue: circular buffer of {pc, insn}, with count.

Issue:
- req_valid_o = !rst && !redirect_i && (count + outstanding < QDEPTH).
- req_addr_o = fetch_pc.
- On req_valid_o && req_ready_i: fetch_pc += 4 and outstanding += 1.
- fetch_pc wraps modulo 2^AWIDTH.

Response:
- On rsp_valid_i: outstanding -= 1.
- If drop > 0: drop -= 1 and the data is discarded.
- Otherwise push {rsp_pc, rsp_data_i} and rsp_pc += 4.
- The credit rule guarantees no overflow. A push into a full queue is a bench error.

Dequeue:
- On valid_o && ready_i: pop the head.
- Push and pop may occur in the same cycle; count is unchanged.

Outputs:
- valid_o = (count != 0).
- pc_o and insn_o show the head entry, or 0 when the queue is empty.

Redirect, when redirect_i is high:
- Flush the queue: count = 0 and pointers reset.
- fetch_pc and rsp_pc are set to {redirect_pc_i[AWIDTH-1:2], 2'b00}.
- drop = outstanding - rsp_valid_i; outstanding itself is updated normally by the response.
- A pop handshaked in the same cycle counts as consumed by decode.
- No request is issued, because req_valid_o is low.

Priority: rst > redirect_i > normal issue/response/dequeue.

Reset values, applied while rst is high and in the cycle after:
- fetch_pc = rsp_pc = BASEADDR; outstanding = drop = count = 0.
- valid_o = 0, pc_o = 0, insn_o = 0, req_valid_o = 0.
- rst mid-operation drops all in-flight responses without tracking them. The memory model must also be reset.

## Timing
- First cycle after rst falls: req_valid_o = 1, req_addr_o = BASEADDR.
- Response to queue: rsp_valid_i in cycle N gives valid_o = 1 in cycle N+1 (registered push, no bypass).
- Redirect in cycle N: req_addr_o = target in cycle N+1. With 1-cycle memory, the earliest valid_o for the target is cycle N+3.
- Throughput is one instruction per cycle when memory latency L satisfies QDEPTH >= L+1 and decode is always ready.
- With ready_i held low, the queue fills to QDEPTH and req_valid_o stays low until a pop frees a credit. The freed credit is visible the cycle after the pop.
- req_addr_o is stable while req_valid_o is high and req_ready_i is low.

## Test plan
- Reset, then 1-cycle memory with ready_i = 1 -> valid_o rises in the 3rd cycle after reset. pc_o then reads 0x01000000, 0x01000004, ... one per cycle; insn_o matches memory.
- ready_i = 0 for 10 cycles, QDEPTH = 4 -> count saturates at 4 and req_valid_o = 0. Releasing ready_i drains in order with no loss or duplicate PCs.
- 3-cycle memory latency with 3 requests in flight, then redirect_i to 0x01000103 -> the 3 stale responses are discarded. The next pc_o is 0x01000100, then 0x01000104.
- Redirect asserted in the same cycle as rsp_valid_i and a valid_o && ready_i pop -> the response is dropped, the queue is empty next cycle, and drop = outstanding - 1.
- req_ready_i randomly stalled (50%) -> req_addr_o is held stable during stalls and the PC sequence stays contiguous.
- rst asserted mid-stream with the queue non-empty -> the next cycle shows valid_o = 0, pc_o = 0, req_valid_o = 0. Fetch restarts at 0x01000000.
